seq_exec_ctrl: RTL and testbench

Instruction-execution controller for the bus sequencer. After a start pulse it fetches 13-bit command words from the synchronous sequence ROM, beginning at a given address. It decodes each word and dispatches it to the SPI byte engine, the I2C bit-level engine or an internal delay counter. Each command is a one-cycle request, and the controller waits for the engine's done pulse before fetching the next word. It sits between the top-level start/ready handshake and the ROM and protocol engines, and owns sequence flow, error reporting and read-data return.

---
 rtl/seq_exec_ctrl_if.sv | 45 ++++
 rtl/seq_exec_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_seq_exec_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_exec_ctrl_if.sv
// rtl/seq_exec_ctrl_if.sv - start/ready, ROM and protocol-engine signals of the sequencer controller
interface seq_exec_ctrl_if #(
    parameter int ADDRESS_WIDTH = 8
);
    logic                     start_i;
    logic [ADDRESS_WIDTH-1:0] start_addr_i;
    logic                     ready_o;
    logic                     done_o;
    logic [1:0]               err_o;
    logic [ADDRESS_WIDTH-1:0] rom_addr_o;
    logic                     rom_rden_o;
    logic [12:0]              rom_data_i;
    logic                     spi_req_o;
    logic                     spi_last_o;
    logic [7:0]               spi_tx_o;
    logic                     spi_done_i;
    logic [7:0]               spi_rx_i;
    logic                     i2c_req_o;
    logic [1:0]               i2c_cmd_o;
    logic [7:0]               i2c_tx_o;
    logic                     i2c_nack_o;
    logic                     i2c_done_i;
    logic                     i2c_ack_i;
    logic [7:0]               i2c_rx_i;
    logic [7:0]               rd_data_o;
    logic                     rd_valid_o;

    modport master (
        input  start_i, start_addr_i, rom_data_i, spi_done_i, spi_rx_i,
               i2c_done_i, i2c_ack_i, i2c_rx_i,
        output ready_o, done_o, err_o, rom_addr_o, rom_rden_o,
               spi_req_o, spi_last_o, spi_tx_o,
               i2c_req_o, i2c_cmd_o, i2c_tx_o, i2c_nack_o,
               rd_data_o, rd_valid_o
    );

    modport slave (
        output start_i, start_addr_i, rom_data_i, spi_done_i, spi_rx_i,
               i2c_done_i, i2c_ack_i, i2c_rx_i,
        input  ready_o, done_o, err_o, rom_addr_o, rom_rden_o,
               spi_req_o, spi_last_o, spi_tx_o,
               i2c_req_o, i2c_cmd_o, i2c_tx_o, i2c_nack_o,
               rd_data_o, rd_valid_o
    );
endinterface

// File: rtl/seq_exec_ctrl.sv
// rtl/seq_exec_ctrl.sv - fetches ROM command words and dispatches them to SPI, I2C or delay
module seq_exec_ctrl #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DELAY_SHIFT   = 4
) (
    input  logic           clk_i,
    input  logic           nrst_i,
    seq_exec_ctrl_if.master bus
);
    localparam int CW = 8 + DELAY_SHIFT;

    localparam logic [2:0] OP_END       = 3'd0;
    localparam logic [2:0] OP_SPI       = 3'd1;
    localparam logic [2:0] OP_I2C_START = 3'd2;
    localparam logic [2:0] OP_I2C_WRITE = 3'd3;
    localparam logic [2:0] OP_I2C_READ  = 3'd4;
    localparam logic [2:0] OP_I2C_STOP  = 3'd5;
    localparam logic [2:0] OP_WAIT      = 3'd6;
    localparam logic [2:0] OP_ILLEGAL   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_SPI_WAIT, S_I2C_WAIT, S_DELAY
    } state_t;

    state_t                   state, state_next;
    logic [ADDRESS_WIDTH-1:0] pc, pc_next;
    logic [CW-1:0]            count, count_next;
    logic [1:0]               err, err_next;
    logic [2:0]               ir_op;
    logic                     ir_capture;
    logic                     complete;
    logic                     spi_req, spi_last, i2c_req, i2c_nack, done, rd_valid;
    logic [7:0]               spi_tx, i2c_tx, rd_data;
    logic [1:0]               i2c_cmd;

    logic [2:0] op_rom;
    logic [7:0] data_rom;
    logic       spi_accept, i2c_accept, at_top;

    assign op_rom   = bus.rom_data_i[12:10];
    assign data_rom = bus.rom_data_i[7:0];
    // A done coinciding with our own request pulse belongs to nothing we issued.
    assign spi_accept = (state == S_SPI_WAIT) && bus.spi_done_i && !spi_req;
    assign i2c_accept = (state == S_I2C_WAIT) && bus.i2c_done_i && !i2c_req;
    assign at_top     = (pc == {ADDRESS_WIDTH{1'b1}});

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        err_next   = err;
        count_next = count;
        complete   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_next = S_FETCH;
                    pc_next    = bus.start_addr_i;
                    err_next   = 2'd0;
                end
            end
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                case (op_rom)
                    OP_END: state_next = S_IDLE;
                    OP_ILLEGAL: begin
                        state_next = S_IDLE;
                        err_next   = 2'd2;
                    end
                    OP_SPI: state_next = S_SPI_WAIT;
                    OP_WAIT: begin
                        count_next = CW'(data_rom) << DELAY_SHIFT;
                        if (data_rom == 8'd0) begin
                            complete = 1'b1;
                        end else begin
                            state_next = S_DELAY;
                        end
                    end
                    default: state_next = S_I2C_WAIT;
                endcase
            end
            S_SPI_WAIT: complete = spi_accept;
            S_I2C_WAIT: begin
                if (i2c_accept) begin
                    if (ir_op == OP_I2C_WRITE && !bus.i2c_ack_i) begin
                        state_next = S_IDLE;
                        err_next   = 2'd1;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            S_DELAY: begin
                count_next = count - CW'(1);
                complete   = (count == CW'(1));
            end
            default: state_next = S_IDLE;
        endcase
        // The last ROM address never wraps back to zero.
        if (complete) begin
            if (at_top) begin
                state_next = S_IDLE;
                err_next   = 2'd3;
            end else begin
                state_next = S_FETCH;
                pc_next    = pc + ADDRESS_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            pc         <= '0;
            count      <= '0;
            err        <= 2'd0;
            ir_op      <= 3'd0;
            ir_capture <= 1'b0;
            done       <= 1'b0;
            spi_req    <= 1'b0;
            spi_last   <= 1'b0;
            spi_tx     <= 8'd0;
            i2c_req    <= 1'b0;
            i2c_cmd    <= 2'd0;
            i2c_tx     <= 8'd0;
            i2c_nack   <= 1'b0;
            rd_data    <= 8'd0;
            rd_valid   <= 1'b0;
        end else begin
            pc       <= pc_next;
            count    <= count_next;
            err      <= err_next;
            done     <= (state != S_IDLE) && (state_next == S_IDLE);
            spi_req  <= 1'b0;
            i2c_req  <= 1'b0;
            rd_valid <= 1'b0;
            if (state == S_DECODE) begin
                ir_op      <= op_rom;
                ir_capture <= bus.rom_data_i[9];
                case (op_rom)
                    OP_SPI: begin
                        spi_req  <= 1'b1;
                        spi_tx   <= data_rom;
                        spi_last <= bus.rom_data_i[8];
                    end
                    OP_I2C_START: begin
                        i2c_req <= 1'b1;
                        i2c_cmd <= 2'd0;
                    end
                    OP_I2C_WRITE: begin
                        i2c_req <= 1'b1;
                        i2c_cmd <= 2'd1;
                        i2c_tx  <= data_rom;
                    end
                    OP_I2C_READ: begin
                        i2c_req  <= 1'b1;
                        i2c_cmd  <= 2'd2;
                        i2c_nack <= bus.rom_data_i[8];
                    end
                    OP_I2C_STOP: begin
                        i2c_req <= 1'b1;
                        i2c_cmd <= 2'd3;
                    end
                    default: ;
                endcase
            end
            if (spi_accept && ir_capture) begin
                rd_data  <= bus.spi_rx_i;
                rd_valid <= 1'b1;
            end
            if (i2c_accept && ir_op == OP_I2C_READ) begin
                rd_data  <= bus.i2c_rx_i;
                rd_valid <= 1'b1;
            end
        end
    end

    assign bus.ready_o    = (state == S_IDLE);
    assign bus.rom_rden_o = (state == S_FETCH);
    assign bus.rom_addr_o = pc;
    assign bus.done_o     = done;
    assign bus.err_o      = err;
    assign bus.spi_req_o  = spi_req;
    assign bus.spi_last_o = spi_last;
    assign bus.spi_tx_o   = spi_tx;
    assign bus.i2c_req_o  = i2c_req;
    assign bus.i2c_cmd_o  = i2c_cmd;
    assign bus.i2c_tx_o   = i2c_tx;
    assign bus.i2c_nack_o = i2c_nack;
    assign bus.rd_data_o  = rd_data;
    assign bus.rd_valid_o = rd_valid;
endmodule

// File: tb/tb_seq_exec_ctrl.sv
// tb/tb_seq_exec_ctrl.sv - directed bench for seq_exec_ctrl with ROM and engine models
module tb_seq_exec_ctrl;
    logic clk = 1'b0;
    logic nrst_i;
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_exec_ctrl_if #(.ADDRESS_WIDTH(8)) bus();

    seq_exec_ctrl #(.ADDRESS_WIDTH(8), .DELAY_SHIFT(4)) dut (
        .clk_i  (clk),
        .nrst_i (nrst_i),
        .bus    (bus.master)
    );

    logic [12:0] rom [256];
    always @(posedge clk) if (bus.rom_rden_o) bus.rom_data_i <= rom[bus.rom_addr_o];

    int spi_lat, i2c_lat, spi_cd, i2c_cd, spur_cd;
    bit spi_echo, spur;

    always @(negedge clk) begin
        bus.spi_done_i = 1'b0;
        bus.i2c_done_i = 1'b0;
        if (!nrst_i) begin
            spi_cd = 0; i2c_cd = 0; spur_cd = 0;
        end else begin
            if (spi_cd > 0) begin spi_cd--; if (spi_cd == 0) bus.spi_done_i = 1'b1; end
            if (i2c_cd > 0) begin i2c_cd--; if (i2c_cd == 0) bus.i2c_done_i = 1'b1; end
            if (spur_cd > 0) begin spur_cd--; if (spur_cd == 0) bus.i2c_done_i = 1'b1; end
            if (bus.spi_req_o) begin
                spi_cd = spi_lat;
                if (spi_echo) bus.spi_done_i = 1'b1;
                if (spur) spur_cd = 1;
            end
            if (bus.i2c_req_o) i2c_cd = i2c_lat;
        end
    end

    int fetch_a[$], fetch_c[$], spi_q[$], spi_c[$], i2c_q[$], i2c_c[$], rd_q[$], rd_c[$];
    int done_cnt, done_c, done_err;

    always @(negedge clk) if (nrst_i) begin
        if (bus.rom_rden_o) begin fetch_a.push_back(int'(bus.rom_addr_o)); fetch_c.push_back(cyc); end
        if (bus.spi_req_o) begin spi_q.push_back(int'({bus.spi_last_o, bus.spi_tx_o})); spi_c.push_back(cyc); end
        if (bus.i2c_req_o) begin
            i2c_q.push_back(int'({bus.i2c_cmd_o, bus.i2c_nack_o, bus.i2c_tx_o}));
            i2c_c.push_back(cyc);
        end
        if (bus.rd_valid_o) begin rd_q.push_back(int'(bus.rd_data_o)); rd_c.push_back(cyc); end
        if (bus.done_o) begin done_cnt++; done_c = cyc; done_err = int'(bus.err_o); end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] w(input logic [2:0] op, input logic cap, input logic flag,
                                      input logic [7:0] d);
        return {op, cap, flag, d};
    endfunction

    task automatic clear_logs();
        fetch_a.delete(); fetch_c.delete(); spi_q.delete(); spi_c.delete();
        i2c_q.delete(); i2c_c.delete(); rd_q.delete(); rd_c.delete();
        done_cnt = 0; done_c = 0; done_err = -1;
    endtask

    task automatic start_seq(input logic [7:0] a, output int n);
        clear_logs();
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.start_addr_i = a;
        @(posedge clk);
        #1;
        n = cyc;
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin @(negedge clk); k++; end
        @(negedge clk);
        #1;
        check({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    int n;

    initial begin
        nrst_i = 1'b0;
        bus.start_i = 1'b0; bus.start_addr_i = 8'd0;
        bus.spi_rx_i = 8'h00; bus.i2c_rx_i = 8'h00; bus.i2c_ack_i = 1'b1;
        bus.spi_done_i = 1'b0; bus.i2c_done_i = 1'b0;
        spi_lat = 3; i2c_lat = 2; spi_echo = 0; spur = 0;
        for (int i = 0; i < 256; i++) rom[i] = 13'd0;
        rom[8'h10] = w(3'b001, 1'b0, 1'b0, 8'hA5);
        rom[8'h11] = w(3'b001, 1'b0, 1'b1, 8'h3C);
        rom[8'h20] = w(3'b010, 1'b0, 1'b0, 8'h00);
        rom[8'h21] = w(3'b011, 1'b0, 1'b0, 8'h50);
        rom[8'h22] = w(3'b100, 1'b0, 1'b1, 8'h00);
        rom[8'h23] = w(3'b101, 1'b0, 1'b0, 8'h00);
        rom[8'h30] = w(3'b011, 1'b0, 1'b0, 8'hA0);
        rom[8'h31] = w(3'b001, 1'b0, 1'b0, 8'h11);
        rom[8'h40] = w(3'b110, 1'b0, 1'b0, 8'h03);
        rom[8'h41] = w(3'b110, 1'b0, 1'b0, 8'h00);
        rom[8'h50] = w(3'b111, 1'b0, 1'b0, 8'h00);
        rom[8'h60] = w(3'b001, 1'b0, 1'b0, 8'h5A);
        rom[8'hFF] = w(3'b001, 1'b0, 1'b1, 8'h77);
        clear_logs();

        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", bus.ready_o, 1);
        check("rst_outs", {bus.done_o, bus.err_o, bus.rom_rden_o, bus.spi_req_o, bus.i2c_req_o, bus.rd_valid_o}, 0);
        check("rst_payload", {bus.rom_addr_o, bus.spi_tx_o, bus.i2c_tx_o, bus.i2c_cmd_o, bus.rd_data_o}, 0);
        @(negedge clk);
        nrst_i = 1'b1;

        // SPI pair with an echo done, a stray I2C done and a start while busy
        spi_echo = 1; spur = 1;
        start_seq(8'h10, n);
        check("spi_busy_ready", bus.ready_o, 0);
        repeat (2) @(negedge clk);
        bus.start_i = 1'b1; bus.start_addr_i = 8'h50;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_done("spi", 100);
        check("spi_req_cnt", spi_q.size(), 2);
        check("spi_word0", spi_q[0], 32'h0A5);
        check("spi_word1", spi_q[1], 32'h13C);
        check("spi_req_lat", spi_c[0] - n, 2);
        check("spi_done_to_fetch", fetch_c[1] - spi_c[0], 4);
        check("spi_fetch_cnt", fetch_a.size(), 3);
        check("spi_fetch_last", fetch_a[2], 32'h12);
        check("spi_done_lat", done_c - n, 14);
        check("spi_err", done_err, 0);
        check("spi_rd_cnt", rd_q.size(), 0);
        spi_echo = 0; spur = 0;

        bus.i2c_rx_i = 8'h9E; bus.i2c_ack_i = 1'b1;
        start_seq(8'h20, n);
        wait_done("i2c", 100);
        check("i2c_req_cnt", i2c_q.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("i2c_cmd%0d", i), i2c_q[i] >> 9, i);
        check("i2c_wr_tx", i2c_q[1] & 32'hFF, 32'h50);
        check("i2c_rd_nack", (i2c_q[2] >> 8) & 1, 1);
        check("i2c_rd_cnt", rd_q.size(), 1);
        check("i2c_rd_data", rd_q[0], 32'h9E);
        check("i2c_rd_lat", rd_c[0] - i2c_c[2], 3);
        check("i2c_err", done_err, 0);

        bus.i2c_ack_i = 1'b0;
        start_seq(8'h30, n);
        wait_done("nack", 100);
        check("nack_err", done_err, 1);
        check("nack_fetch_cnt", fetch_a.size(), 1);
        check("nack_done_lat", done_c - i2c_c[0], 3);
        check("nack_err_held", bus.err_o, 1);
        bus.i2c_ack_i = 1'b1;

        start_seq(8'h40, n);
        wait_done("wait", 200);
        check("wait_48", fetch_c[1] - fetch_c[0], 50);
        check("wait_0", fetch_c[2] - fetch_c[1], 2);
        check("wait_err", done_err, 0);

        start_seq(8'h50, n);
        wait_done("ill", 50);
        check("ill_err", done_err, 2);
        check("ill_done_lat", done_c - n, 2);
        check("ill_fetch_cnt", fetch_a.size(), 1);

        start_seq(8'hFF, n);
        wait_done("ovr", 100);
        check("ovr_spi_cnt", spi_q.size(), 1);
        check("ovr_spi_word", spi_q[0], 32'h177);
        check("ovr_err", done_err, 3);
        check("ovr_fetch_cnt", fetch_a.size(), 1);

        // Reset while the SPI engine is still busy
        spi_lat = 20;
        start_seq(8'h60, n);
        for (int k = 0; k < 20 && spi_c.size() == 0; k++) @(negedge clk);
        check("rst_spi_seen", spi_c.size(), 1);
        @(negedge clk);
        nrst_i = 1'b0;
        #1;
        check("mid_rst_ready", bus.ready_o, 1);
        check("mid_rst_outs", {bus.done_o, bus.err_o, bus.rom_rden_o, bus.spi_req_o, bus.i2c_req_o, bus.rd_valid_o}, 0);
        check("mid_rst_payload", {bus.rom_addr_o, bus.spi_tx_o, bus.i2c_tx_o, bus.i2c_cmd_o, bus.rd_data_o}, 0);
        @(negedge clk);
        nrst_i = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check("mid_rst_no_done", done_cnt, 0);
        check("mid_rst_idle", bus.ready_o, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
